// File: rtl/fisc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fisc_fetch_pkg
// Purpose  : Shared types and helper functions for the FISC fetch unit.
//            - fetch_state_t  : fetch FSM state encoding
//            - slots_per_word : instructions carried by one memory word
//            - word_off_shift : byte-to-word address shift for a memory width
// Revision : 1.0 - initial release
// ============================================================================
package fisc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_UNPACK  = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

    function automatic int slots_per_word(input int mem_w, input int insn_w);
        return mem_w / insn_w;
    endfunction

    function automatic int word_off_shift(input int mem_w);
        return $clog2(mem_w / 8);
    endfunction

    // Shift for the default 64-bit memory word.
    localparam int C_DEF_WORD_OFF_SH = word_off_shift(64);

endpackage
`default_nettype wire

// File: rtl/fisc_insn_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fisc_insn_fifo
// Purpose  : Synchronous instruction FIFO between the fetch FSM and decode.
//            Head entry is read straight out of the storage registers, so it
//            stays stable until popped. Push and pop may coincide when full.
// Ports    : clk, rst (async, active-high), i_flush (empties the FIFO),
//            i_push/i_data, i_pop, o_data (head), o_full, o_empty
// Revision : 1.0 - initial release
// ============================================================================
module fisc_insn_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int C_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_PTR_W:0]   r_count;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_count == (C_PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (C_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (C_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/fisc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fisc_fetch_unit
// Purpose  : Instruction fetch unit. Reads MEM_W-bit words from memory
//            channel A, unpacks them lowest slot first into INSN_W-bit
//            instructions and queues {insn, pc} toward decode. Redirects
//            flush the queue; a response already in flight when a redirect
//            arrives is waited for and dropped.
// Ports    : clk, reset (async, active-high)
//            run, redirect, redirect_pc        - core control
//            mem_rd, mem_addr, mem_rvalid, mem_rdata - memory channel A
//            insn_valid, insn, insn_pc, insn_ready   - decode side
//            fault                             - sticky misaligned redirect
//            perf_words, perf_flushes          - performance counters
// Macro    : FISC_FETCH_PERF_EN - builds saturating perf counters; when
//            undefined both perf outputs are constant 0.
// Revision : 1.0 - initial release
// ============================================================================
module fisc_fetch_unit
    import fisc_fetch_pkg::*;
#(
    parameter int                MEM_W      = 64,
    parameter int                INSN_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BOOT_ADDR  = '0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                run,
    input  logic                                redirect,
    input  logic [ADDR_W-1:0]                   redirect_pc,
    output logic                                mem_rd,
    output logic [ADDR_W-$clog2(MEM_W/8)-1:0]   mem_addr,
    input  logic                                mem_rvalid,
    input  logic [MEM_W-1:0]                    mem_rdata,
    output logic                                insn_valid,
    output logic [INSN_W-1:0]                   insn,
    output logic [ADDR_W-1:0]                   insn_pc,
    input  logic                                insn_ready,
    output logic                                fault,
    output logic [31:0]                         perf_words,
    output logic [31:0]                         perf_flushes
);
    localparam int C_SLOTS   = slots_per_word(MEM_W, INSN_W);
    localparam int C_WOFF_SH = word_off_shift(MEM_W);
    localparam int C_STEP    = INSN_W / 8;
    localparam int C_ISH     = $clog2(C_STEP);
    localparam int C_SLOT_W  = (C_SLOTS > 1) ? $clog2(C_SLOTS) : 1;
    localparam int C_WADDR_W = ADDR_W - C_WOFF_SH;

    localparam logic [ADDR_W-1:0]   C_STEP_A    = ADDR_W'(C_STEP);
    localparam logic [ADDR_W-1:0]   C_INSN_MASK = ADDR_W'(C_STEP - 1);
    localparam logic [ADDR_W-1:0]   C_SLOT_MASK = ADDR_W'(C_SLOTS - 1);
    localparam logic [C_SLOT_W-1:0] C_LAST_SLOT = C_SLOT_W'(C_SLOTS - 1);

    function automatic logic [C_WADDR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:C_WOFF_SH];
    endfunction

    function automatic logic [C_SLOT_W-1:0] slot_of(input logic [ADDR_W-1:0] a);
        return C_SLOT_W'((a >> C_ISH) & C_SLOT_MASK);
    endfunction

    fetch_state_t                      r_state;
    logic [ADDR_W-1:0]                 r_pc;
    logic [C_SLOT_W-1:0]               r_slot;
    logic                              r_mem_rd;
    logic [C_WADDR_W-1:0]              r_mem_addr;
    logic                              r_fault;
    logic [C_SLOTS-1:0][INSN_W-1:0]    r_line;

    fetch_state_t                      w_state_nxt;
    logic [ADDR_W-1:0]                 w_pc_nxt;
    logic [C_SLOT_W-1:0]               w_slot_nxt;
    logic                              w_mem_rd_nxt;
    logic [C_WADDR_W-1:0]              w_mem_addr_nxt;
    logic                              w_fault_nxt;
    logic                              w_line_load;
    logic                              w_push;
    logic                              w_pop;
    logic                              w_full;
    logic                              w_empty;
    logic                              w_misalign;
    logic [ADDR_W-1:0]                 w_pc_inc;
    logic [INSN_W+ADDR_W-1:0]          w_fifo_out;

    assign w_misalign = |(redirect_pc & C_INSN_MASK);
    assign w_pc_inc   = r_pc + C_STEP_A;
    // A redirect flushes the FIFO, so a coincident pop must not count.
    assign w_pop      = insn_ready && insn_valid && !redirect;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_slot_nxt     = r_slot;
        w_mem_rd_nxt   = r_mem_rd;
        w_mem_addr_nxt = r_mem_addr;
        w_fault_nxt    = r_fault;
        w_line_load    = 1'b0;
        w_push         = 1'b0;

        if (redirect) begin
            if (w_misalign) begin
                w_fault_nxt = 1'b1;
            end else begin
                w_fault_nxt = 1'b0;
                w_pc_nxt    = redirect_pc;
            end
            // An unanswered request must run to completion; keep mem_rd and
            // the old address and drop whatever comes back.
            if ((r_state == ST_REQ || r_state == ST_DISCARD) && !mem_rvalid) begin
                w_state_nxt = ST_DISCARD;
            end else if (w_fault_nxt || !run) begin
                w_state_nxt  = ST_IDLE;
                w_mem_rd_nxt = 1'b0;
            end else begin
                w_state_nxt    = ST_REQ;
                w_mem_rd_nxt   = 1'b1;
                w_mem_addr_nxt = word_of(w_pc_nxt);
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run && !r_fault) begin
                        w_state_nxt    = ST_REQ;
                        w_mem_rd_nxt   = 1'b1;
                        w_mem_addr_nxt = word_of(r_pc);
                    end
                end
                ST_REQ: begin
                    if (mem_rvalid) begin
                        w_line_load  = 1'b1;
                        w_slot_nxt   = slot_of(r_pc);
                        w_mem_rd_nxt = 1'b0;
                        w_state_nxt  = ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    if (!w_full || w_pop) begin
                        w_push     = 1'b1;
                        w_pc_nxt   = w_pc_inc;
                        w_slot_nxt = r_slot + C_SLOT_W'(1);
                        if (r_slot == C_LAST_SLOT) begin
                            if (run) begin
                                w_state_nxt    = ST_REQ;
                                w_mem_rd_nxt   = 1'b1;
                                w_mem_addr_nxt = word_of(w_pc_inc);
                            end else begin
                                w_state_nxt = ST_IDLE;
                            end
                        end
                    end
                end
                ST_DISCARD: begin
                    if (mem_rvalid) begin
                        if (r_fault || !run) begin
                            w_state_nxt  = ST_IDLE;
                            w_mem_rd_nxt = 1'b0;
                        end else begin
                            w_state_nxt    = ST_REQ;
                            w_mem_rd_nxt   = 1'b1;
                            w_mem_addr_nxt = word_of(r_pc);
                        end
                    end
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_mem_rd_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= BOOT_ADDR;
            r_slot     <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_fault    <= 1'b0;
            r_line     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_slot     <= w_slot_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_fault    <= w_fault_nxt;
            if (w_line_load) r_line <= mem_rdata;
        end
    end

    fisc_insn_fifo #(
        .WIDTH (INSN_W + ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_data  ({r_line[r_slot], r_pc}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign mem_rd     = r_mem_rd;
    assign mem_addr   = r_mem_addr;
    assign fault      = r_fault;
    assign insn_valid = !w_empty;
    assign insn       = w_fifo_out[INSN_W+ADDR_W-1:ADDR_W];
    assign insn_pc    = w_fifo_out[ADDR_W-1:0];

`ifdef FISC_FETCH_PERF_EN
    logic [31:0] r_perf_words;
    logic [31:0] r_perf_flushes;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_words   <= '0;
            r_perf_flushes <= '0;
        end else begin
            // Every completed request counts, dropped responses included.
            if (r_mem_rd && mem_rvalid && (r_perf_words != '1))
                r_perf_words <= r_perf_words + 32'd1;
            if (redirect && (r_perf_flushes != '1))
                r_perf_flushes <= r_perf_flushes + 32'd1;
        end
    end

    assign perf_words   = r_perf_words;
    assign perf_flushes = r_perf_flushes;
`else
    assign perf_words   = '0;
    assign perf_flushes = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fisc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fisc_fetch_unit
// Purpose  : Directed self-checking bench for fisc_fetch_unit (default
//            64-bit words, 32-bit instructions, 4-entry FIFO). Memory word
//            contents are derived from byte PC so every instruction is
//            identifiable: insn(pc) = 0x11111111 * (pc/4 + 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fisc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_rd;
    logic [28:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_ready = 1'b0;
    logic        fault;
    logic [31:0] perf_words;
    logic [31:0] perf_flushes;

    int n_cmp = 0;
    int n_bad = 0;
    int lat   = 0;
    int mcnt  = 0;
    logic [31:0] exp_w;
    logic [31:0] exp_f;

    fisc_fetch_unit #(
        .MEM_W      (64),
        .INSN_W     (32),
        .ADDR_W     (32),
        .FIFO_DEPTH (4),
        .BOOT_ADDR  (32'h0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .insn_valid   (insn_valid),
        .insn         (insn),
        .insn_pc      (insn_pc),
        .insn_ready   (insn_ready),
        .fault        (fault),
        .perf_words   (perf_words),
        .perf_flushes (perf_flushes)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] p);
        return 32'h11111111 * ((p >> 2) + 32'd1);
    endfunction

    function automatic logic [63:0] word_data(input logic [28:0] a);
        logic [31:0] b;
        b = {a, 3'b000};
        return {f(b + 32'd4), f(b)};
    endfunction

    // Memory responder: answers after `lat` idle cycles, one-cycle rvalid.
    always @(negedge clk) begin
        if (reset) begin
            mem_rvalid = 1'b0;
            mcnt       = 0;
        end else if (mem_rvalid) begin
            mem_rvalid = 1'b0;
            mcnt       = 0;
        end else if (mem_rd) begin
            if (mcnt >= lat) begin
                mem_rvalid = 1'b1;
                mem_rdata  = word_data(mem_addr);
            end else begin
                mcnt = mcnt + 1;
            end
        end else begin
            mcnt = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        redirect    = 1'b0;
    endtask

    task automatic wait_insn(input string tag, input logic [31:0] ei, input logic [31:0] ep);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (insn_valid === 1'b1) break;
        end
        check({tag, ".valid"}, insn_valid, 1);
        check({tag, ".insn"},  insn, ei);
        check({tag, ".pc"},    insn_pc, ep);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(3);
        check("rst.mem_rd",     mem_rd, 0);
        check("rst.mem_addr",   mem_addr, 0);
        check("rst.insn_valid", insn_valid, 0);
        check("rst.fault",      fault, 0);
        check("rst.perf_words", perf_words, 0);
        check("rst.perf_flush", perf_flushes, 0);

        // Boot fetch from 0
        reset      = 1'b0;
        run        = 1'b1;
        insn_ready = 1'b1;
        wait_insn("w0s0", 32'h11111111, 32'h0);
        wait_insn("w0s1", 32'h22222222, 32'h4);
        check("w0.next_addr", mem_addr, 1);
        check("w0.next_rd",   mem_rd, 1);
        run = 1'b0;
        wait_insn("w1s0", 32'h33333333, 32'h8);
        wait_insn("w1s1", 32'h44444444, 32'hC);
        cyc(3);
        check("idle.mem_rd", mem_rd, 0);
        check("idle.empty",  insn_valid, 0);

        // Redirect into the upper slot of word 1 (zero-wait memory timing)
        run = 1'b1;
        do_redirect(32'h0000000C);
        check("rdC.mem_rd",   mem_rd, 1);
        check("rdC.mem_addr", mem_addr, 1);
        cyc(1);
        check("rdC.not_yet",  insn_valid, 0);
        cyc(1);
        check("rdC.valid",    insn_valid, 1);
        check("rdC.insn",     insn, 32'h44444444);
        check("rdC.pc",       insn_pc, 32'hC);
        check("rdC.next",     mem_addr, 2);
        run = 1'b0;
        wait_insn("w2s0", 32'h55555555, 32'h10);
        wait_insn("w2s1", 32'h66666666, 32'h14);
        cyc(3);

        // Redirect while a slow request is outstanding
        lat = 5;
        run = 1'b1;
        cyc(2);
        check("disc.pre_addr", mem_addr, 3);
        check("disc.pre_rd",   mem_rd, 1);
        do_redirect(32'h00000040);
        check("disc.hold_addr", mem_addr, 3);
        check("disc.hold_rd",   mem_rd, 1);
        check("disc.empty",     insn_valid, 0);
        for (int i = 0; i < 30; i++) begin
            if (mem_addr !== 29'd3) break;
            @(negedge clk);
        end
        check("disc.new_addr", mem_addr, 8);
        check("disc.new_rd",   mem_rd, 1);
        check("disc.no_stale", insn_valid, 0);
        run = 1'b0;
        wait_insn("w8s0", f(32'h40), 32'h40);
        wait_insn("w8s1", f(32'h44), 32'h44);
        cyc(3);

        // Back-pressure: FIFO fills, unpack stalls, nothing lost on resume
        lat        = 0;
        insn_ready = 1'b0;
        run        = 1'b1;
        cyc(25);
        check("full.valid",    insn_valid, 1);
        check("full.insn",     insn, f(32'h48));
        check("full.pc",       insn_pc, 32'h48);
        check("full.stall_rd", mem_rd, 0);
        run        = 1'b0;
        insn_ready = 1'b1;
        for (int a = 32'h4C; a < 32'h60; a += 4)
            wait_insn("drain", f(32'(a)), 32'(a));
        cyc(3);

        // Misaligned redirect with a full FIFO, then recovery
        insn_ready = 1'b0;
        run        = 1'b1;
        cyc(25);
        check("flt.pre_valid", insn_valid, 1);
        check("flt.pre_pc",    insn_pc, 32'h60);
        do_redirect(32'h00000006);
        check("flt.fault",   fault, 1);
        check("flt.flushed", insn_valid, 0);
        check("flt.mem_rd",  mem_rd, 0);
        cyc(4);
        check("flt.sticky",  fault, 1);
        check("flt.no_req",  mem_rd, 0);
        insn_ready = 1'b1;
        do_redirect(32'h00000008);
        check("flt.clear",   fault, 0);
        check("flt.rd",      mem_rd, 1);
        check("flt.addr",    mem_addr, 1);
        run = 1'b0;
        wait_insn("flt.s0", f(32'h8), 32'h8);
        wait_insn("flt.s1", f(32'hC), 32'hC);
        cyc(3);

        // PC wrap from the top of the address space
        run = 1'b1;
        do_redirect(32'hFFFFFFF8);
        wait_insn("wrap.s0", f(32'hFFFFFFF8), 32'hFFFFFFF8);
        wait_insn("wrap.s1", f(32'hFFFFFFFC), 32'hFFFFFFFC);
        check("wrap.addr", mem_addr, 0);
        check("wrap.rd",   mem_rd, 1);
        run = 1'b0;
        cyc(10);

        // Counters: words 0,1,1,2,3(dropped),8,9,10,11,12,13,14,1,top,0;
        // redirects to C, 40, 6, 8, FFFFFFF8
`ifdef FISC_FETCH_PERF_EN
        exp_w = 32'd15;
        exp_f = 32'd5;
`else
        exp_w = 32'd0;
        exp_f = 32'd0;
`endif
        check("perf.words",   perf_words, exp_w);
        check("perf.flushes", perf_flushes, exp_f);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
